perf_event_reader: RTL and testbench

//  Read-side counterpart of the per-module perf-counter macro. Owns NUM_EVENTS

---
 rtl/perf_event_reader.sv | 136 +++++++++++++
 tb/tb_perf_event_reader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/perf_event_reader.sv
// Perf-counter read side: NUM_EVENTS strobe counters with sticky overflow, an
// atomic snapshot bank, and a valid/ready record streamer for the log sink.

module perf_event_cnt #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ev,
    input  logic                 snap_en,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] snap,
    output logic                 snap_ovf
);
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf;
    logic                 wrap;

    assign wrap = ev & (&cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            ovf      <= 1'b0;
            snap     <= '0;
            snap_ovf <= 1'b0;
        end else begin
            if (snap_en) begin
                snap     <= cnt;
                snap_ovf <= ovf;
            end
            // A clearing snapshot still keeps this cycle's strobe
            if (snap_en && clr) begin
                cnt <= CNT_WIDTH'(ev);
                ovf <= 1'b0;
            end else begin
                cnt <= cnt + CNT_WIDTH'(ev);
                if (wrap) ovf <= 1'b1;
            end
        end
    end
endmodule

module perf_event_reader #(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int ID_WIDTH   = $clog2(NUM_EVENTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  dump_req,
    input  logic                  clear_on_dump,
    output logic                  dump_busy,
    output logic                  dump_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [CNT_WIDTH-1:0]  out_value,
    output logic                  out_ovf,
    output logic                  out_last
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_EVENTS - 1);

    state_t                               state, state_n;
    logic [ID_WIDTH-1:0]                  idx, idx_n;
    logic                                 start;
    logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] snap;
    logic [NUM_EVENTS-1:0]                snap_ovf;

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_lane
        perf_event_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .ev       (event_i[g]),
            .snap_en  (start),
            .clr      (clear_on_dump),
            .snap     (snap[g]),
            .snap_ovf (snap_ovf[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        start     = 1'b0;
        out_valid = 1'b0;
        dump_busy = 1'b0;
        dump_done = 1'b0;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    start   = 1'b1;
                    state_n = STREAM;
                    idx_n   = '0;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                dump_busy = 1'b1;
                if (out_ready) begin
                    if (idx == LAST_ID) begin
                        state_n = DONE;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + ID_WIDTH'(1);
                    end
                end
            end
            DONE: begin
                dump_busy = 1'b1;
                dump_done = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs come only from registered state and the snapshot bank
    assign out_id    = idx;
    assign out_value = snap[idx];
    assign out_ovf   = snap_ovf[idx];
    assign out_last  = (state == STREAM) && (idx == LAST_ID);
endmodule

// File: tb/tb_perf_event_reader.sv
// Directed bench for perf_event_reader (8 events, 8-bit counters so wrap is reachable).

module tb_perf_event_reader;
    localparam int NE = 8;
    localparam int CW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NE-1:0] event_i;
    logic          dump_req;
    logic          clear_on_dump;
    logic          dump_busy;
    logic          dump_done;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_id;
    logic [CW-1:0] out_value;
    logic          out_ovf;
    logic          out_last;

    int n_tests = 0;
    int n_fail  = 0;

    logic [NE-1:0][CW-1:0] ev;
    logic [NE-1:0]         eo;

    perf_event_reader #(.NUM_EVENTS(NE), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .event_i       (event_i),
        .dump_req      (dump_req),
        .clear_on_dump (clear_on_dump),
        .dump_busy     (dump_busy),
        .dump_done     (dump_done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_id        (out_id),
        .out_value     (out_value),
        .out_ovf       (out_ovf),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        event_i = '0;
        dump_req = 1'b0;
        clear_on_dump = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Start a dump, stream all records checking against ev/eo, then check DONE and return to IDLE.
    // hold keeps dump_req/clear_on_dump high after the start edge; bp toggles out_ready.
    task automatic dump(input logic clr, input logic bp, input logic hold,
                        input logic [NE-1:0][CW-1:0] xv, input logic [NE-1:0] xo);
        int k;
        int cyc;
        dump_req = 1'b1;
        clear_on_dump = clr;
        out_ready = 1'b0;
        tick();
        dump_req = hold;
        clear_on_dump = hold;
        k = 0;
        cyc = 0;
        while (k < NE && cyc < 64) begin
            out_ready = bp ? cyc[0] : 1'b1;
            chk("valid", 32'(out_valid), 32'd1);
            chk("busy", 32'(dump_busy), 32'd1);
            chk("id", 32'(out_id), 32'(k));
            chk("value", 32'(out_value), 32'(xv[k]));
            chk("ovf", 32'(out_ovf), 32'(xo[k]));
            chk("last", 32'(out_last), 32'(k == NE - 1));
            if (out_ready) k++;
            tick();
            cyc++;
        end
        chk("records", 32'(k), 32'(NE));
        if (!bp) chk("cycles", 32'(cyc), 32'(NE));
        out_ready = 1'b0;
        chk("done_pulse", 32'(dump_done), 32'd1);
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_busy", 32'(dump_busy), 32'd1);
        tick();
        chk("idle_done", 32'(dump_done), 32'd0);
        chk("idle_busy", 32'(dump_busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        dump_req = 1'b0;
        clear_on_dump = 1'b0;
    endtask

    initial begin
        // 1: reset state and basic dump
        do_reset();
        rst = 1'b1;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(dump_busy), 32'd0);
        chk("rst_done", 32'(dump_done), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_id", 32'(out_id), 32'd0);
        rst = 1'b0;
        event_i = 8'h08;
        repeat (5) tick();
        event_i = '0;
        ev = '0; ev[3] = 8'd5; eo = '0;
        dump(1'b0, 1'b0, 1'b0, ev, eo);

        // 2: clear_on_dump keeps the dump-cycle event
        do_reset();
        event_i = 8'h01;
        repeat (4) tick();
        ev = '0; ev[0] = 8'd4; eo = '0;
        dump(1'b1, 1'b0, 1'b0, ev, eo);
        // 1 at T, then 8 accept edges and the DONE edge
        ev = '0; ev[0] = 8'd10;
        dump(1'b0, 1'b0, 1'b0, ev, eo);
        event_i = '0;

        // 3: backpressure
        do_reset();
        event_i = 8'hA5;
        repeat (3) tick();
        event_i = '0;
        ev = '0; ev[0] = 8'd3; ev[2] = 8'd3; ev[5] = 8'd3; ev[7] = 8'd3; eo = '0;
        dump(1'b0, 1'b1, 1'b0, ev, eo);

        // 4: wrap sets sticky overflow; clearing dump resets it
        do_reset();
        event_i = 8'h04;
        repeat (256) tick();
        event_i = '0;
        ev = '0; eo = '0; eo[2] = 1'b1;
        dump(1'b1, 1'b0, 1'b0, ev, eo);
        eo = '0;
        dump(1'b0, 1'b0, 1'b0, ev, eo);

        // 5: dump_req/clear held through STREAM and DONE
        do_reset();
        event_i = 8'h02;
        repeat (2) tick();
        ev = '0; ev[1] = 8'd2; eo = '0;
        dump(1'b1, 1'b0, 1'b1, ev, eo);
        ev = '0; ev[1] = 8'd10;
        dump(1'b0, 1'b0, 1'b0, ev, eo);
        event_i = '0;

        // 6: reset mid-stream
        do_reset();
        event_i = 8'hFF;
        repeat (3) tick();
        event_i = '0;
        dump_req = 1'b1;
        out_ready = 1'b1;
        tick();
        dump_req = 1'b0;
        repeat (4) tick();
        chk("mid_id", 32'(out_id), 32'd4);
        chk("mid_value", 32'(out_value), 32'd3);
        rst = 1'b1;
        tick();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_done", 32'(dump_done), 32'd0);
        chk("mrst_busy", 32'(dump_busy), 32'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("mrst_done2", 32'(dump_done), 32'd0);
        ev = '0; eo = '0;
        dump(1'b0, 1'b0, 1'b0, ev, eo);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
